mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch (IF) requester and the data-access (MEM-stage) requester of the 5-stage MIPS pipeline.
- Sequences each access over a req/ack memory handshake and returns read data to the requester.
- Generates per-requester stall signals that the pipeline controller uses to freeze stages, alongside its existing hazard stalls.
- Data access has priority; a starvation counter guarantees fetch progress.

Parameters:
ADDR_WIDTH, 32, width of all address buses
DATA_WIDTH, 32, width of all data buses
STARVE_LIMIT, 3, consecutive data grants allowed while if_req is pending before fetch is forced (≥1)

Ports:
clk  in  1  main clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request, level; held until if_ready
if_addr  in  ADDR_WIDTH  fetch address
if_rdata  out  DATA_WIDTH  fetched instruction, registered
if_ready  out  1  one-cycle pulse: fetch complete, if_rdata valid
if_stall  out  1  if_req & ~if_ready
d_ren  in  1  data read request, level
d_wen  in  1  data write request, level
d_addr  in  ADDR_WIDTH  data address
d_wdata  in  DATA_WIDTH  store data
d_rdata  out  DATA_WIDTH  load data, registered
d_ready  out  1  one-cycle pulse: data access complete
d_stall  out  1  (d_ren|d_wen) & ~d_ready
mem_req  out  1  memory request, registered
mem_we  out  1  1 = write
mem_addr  out  ADDR_WIDTH  memory address
mem_din  out  DATA_WIDTH  write data to memory
mem_dout  in  DATA_WIDTH  read data, valid in the mem_ack cycle
mem_ack  in  1  memory completes the held request

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; starve_cnt=0.
  - mem_req, mem_we, if_ready, d_ready = 0.
  - mem_addr, mem_din, if_rdata, d_rdata = 0.
  - Reset mid-transaction drops mem_req immediately; the pending access is abandoned with no ready pulse.
- FSM states: IDLE, FETCH, DATA, DONE.
- IDLE:
  - Grant DATA if (d_ren|d_wen) and not (if_req && starve_cnt==STARVE_LIMIT).
  - Otherwise grant FETCH if if_req.
  - Otherwise stay in IDLE.
  - On a grant, register mem_req=1, mem_addr, mem_we (=d_wen for DATA, 0 for FETCH) and mem_din (=d_wdata for DATA).
- FETCH/DATA:
  - mem_req and all mem_* outputs stay stable until mem_ack is sampled high.
  - On mem_ack: mem_req<=0, mem_we<=0, then go to DONE.
  - FETCH captures mem_dout into if_rdata and pulses if_ready.
  - DATA read captures mem_dout into d_rdata and pulses d_ready.
  - DATA write pulses d_ready and leaves d_rdata unchanged.
  - if_ready/d_ready are high during the DONE cycle only.
- DONE: one cycle, then IDLE. No arbitration in DONE; the requester drops or changes its request here, which prevents re-issue.
- Latency: request seen in IDLE at cycle t → mem_req high from t+1 → mem_ack at cycle a → ready high at a+1. Minimum 3 cycles per access (ack in first mem_req cycle).
- Starvation counter:
  - On a DATA grant while if_req=1: starve_cnt += 1, saturating at STARVE_LIMIT.
  - On a FETCH grant, or an IDLE cycle with if_req=0: starve_cnt <= 0.
- d_ren & d_wen both high: treated as a write.
- Requests and addresses are sampled only in IDLE; changes during FETCH/DATA are ignored.
- mem_ack while in IDLE or DONE is ignored.
- Stalls are combinational from the request inputs and the registered ready signals; no reset dependency beyond the ready registers.

Test Plan:
- Single fetch: if_req=1, if_addr=0x100, mem_ack 2 cycles after mem_req with mem_dout=0x2002000A → mem_addr=0x100, mem_we=0; if_ready pulses 1 cycle with if_rdata=0x2002000A; if_stall high until that cycle.
- Collision: if_req and d_ren both high in IDLE, d_addr=0x40 → DATA granted first (mem_addr=0x40); fetch issues after DONE; d_ready precedes if_ready.
- Store: d_wen=1, d_addr=0x44, d_wdata=0xDEADBEEF → mem_we=1, mem_din=0xDEADBEEF held until ack; d_ready pulses; d_rdata unchanged.
- Starvation: data requests continuously high and if_req high, STARVE_LIMIT=3 → exactly 3 DATA grants, then a FETCH grant, then starve_cnt=0.
- Slow memory: mem_ack withheld 10 cycles → mem_req/mem_addr constant; if_addr changes mid-wait have no effect; exactly one ready pulse.
- Async reset: rst_n low during DATA before ack → mem_req=0 immediately, state IDLE; no d_ready pulse after release; a new request is serviced normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access.
// Data wins ties; a starvation counter forces a fetch after STARVE_LIMIT data grants.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_ready,
  output logic                  if_stall,
  input  logic                  d_ren,
  input  logic                  d_wen,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ready,
  output logic                  d_stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  input  logic                  mem_ack
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [CNT_W-1:0] starve_cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic             grant_data_s;
  logic             grant_fetch_s;
  logic             d_any_s;
  logic             force_fetch_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == LIMIT) ? LIMIT : (v + CNT_W'(1));
  endfunction

  assign d_any_s       = d_ren | d_wen;
  assign force_fetch_s = if_req && (starve_cnt_r == LIMIT);
  assign if_stall      = if_req & ~if_ready;
  assign d_stall       = d_any_s & ~d_ready;

  // State and starvation counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      starve_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r      <= state_next_s;
      starve_cnt_r <= cnt_next_s;
    end
  end

  // Next-state, grant decision and starvation counter update.
  always_comb begin
    state_next_s  = state_r;
    cnt_next_s    = starve_cnt_r;
    grant_data_s  = 1'b0;
    grant_fetch_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (d_any_s && !force_fetch_s) begin
          state_next_s = DATA;
          grant_data_s = 1'b1;
          cnt_next_s   = if_req ? sat_inc(starve_cnt_r) : {CNT_W{1'b0}};
        end else if (if_req) begin
          state_next_s  = FETCH;
          grant_fetch_s = 1'b1;
          cnt_next_s    = {CNT_W{1'b0}};
        end else begin
          state_next_s = IDLE;
          cnt_next_s   = {CNT_W{1'b0}};
        end
      end
      FETCH, DATA: begin
        if (mem_ack) begin
          state_next_s = DONE;
        end else begin
          state_next_s = state_r;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Memory-side request registers and requester read-data/ready registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= {ADDR_WIDTH{1'b0}};
      mem_din  <= {DATA_WIDTH{1'b0}};
      if_rdata <= {DATA_WIDTH{1'b0}};
      d_rdata  <= {DATA_WIDTH{1'b0}};
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grant_data_s) begin
            mem_req  <= 1'b1;
            mem_we   <= d_wen;
            mem_addr <= d_addr;
            mem_din  <= d_wdata;
          end else if (grant_fetch_s) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= if_addr;
          end
        end
        FETCH: begin
          if (mem_ack) begin
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            if_rdata <= mem_dout;
            if_ready <= 1'b1;
          end
        end
        DATA: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            d_ready <= 1'b1;
            // mem_we still holds the granted direction in this cycle
            if (!mem_we) begin
              d_rdata <= mem_dout;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: table-driven single accesses, a
// scoreboard of expected grants, and hand sequences for collision, starvation and reset.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        if_stall;
  logic        d_ren;
  logic        d_wen;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        d_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        mem_ack;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready), .if_stall(if_stall),
    .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_ready(d_ready), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_ack(mem_ack)
  );

  typedef struct {
    bit          is_data;
    bit          we;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    bit          is_data;
    bit          ren;
    bit          wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] dout;
    int          delay;
    bit          perturb;
    logic [31:0] exp_addr;
    bit          exp_we;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[7];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_d = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic push(input bit is_data, input bit we, input logic [31:0] addr,
                      input logic [31:0] din, input logic [31:0] dout);
    exp_t e;
    e.is_data = is_data;
    e.we      = we;
    e.addr    = addr;
    e.din     = din;
    e.dout    = dout;
    if (is_data && we) begin
      e.rdata = last_d;
    end else begin
      e.rdata = dout;
      if (is_data) last_d = dout;
    end
    sb.push_back(e);
  endtask

  // Waits for the next grant, checks it against the scoreboard head, acks after
  // 'delay' held cycles and checks the ready pulse.
  task automatic serve(input int delay, input bit keep, input bit perturb);
    exp_t e;
    bit   got;
    got = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      chk1("grant_timeout", mem_req, 1'b1);
      return;
    end
    if (sb.size() == 0) begin
      chk1("scoreboard_empty", 1'b1, 1'b0);
      return;
    end
    e = sb.pop_front();
    chk("grant_addr", mem_addr, e.addr);
    chk1("grant_we", mem_we, e.we);
    if (e.we) chk("grant_din", mem_din, e.din);
    chk1("stall_while_wait", e.is_data ? d_stall : if_stall, 1'b1);
    for (int k = 0; k < delay; k++) begin
      if (perturb) begin
        if_addr = $urandom;
        d_addr  = $urandom;
        d_wdata = $urandom;
      end
      @(negedge clk);
      chk1("hold_req", mem_req, 1'b1);
      chk("hold_addr", mem_addr, e.addr);
      chk1("hold_we", mem_we, e.we);
      if (e.we) chk("hold_din", mem_din, e.din);
      chk1("no_early_ready", if_ready | d_ready, 1'b0);
    end
    mem_ack  = 1'b1;
    mem_dout = e.dout;
    @(negedge clk);
    mem_ack  = 1'b0;
    mem_dout = $urandom;
    chk1("ready_pulse", e.is_data ? d_ready : if_ready, 1'b1);
    chk1("other_ready_low", e.is_data ? if_ready : d_ready, 1'b0);
    chk("rdata", e.is_data ? d_rdata : if_rdata, e.rdata);
    chk1("req_dropped", mem_req, 1'b0);
    chk1("stall_released", e.is_data ? d_stall : if_stall, 1'b0);
    if (!keep) begin
      if (e.is_data) begin
        d_ren = 1'b0;
        d_wen = 1'b0;
      end else begin
        if_req = 1'b0;
      end
    end
    @(negedge clk);
    chk1("ready_one_cycle", if_ready | d_ready, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; if_req = 1'b0; if_addr = 32'h0; d_ren = 1'b0; d_wen = 1'b0;
    d_addr = 32'h0; d_wdata = 32'h0; mem_dout = 32'h0; mem_ack = 1'b0;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h0, 32'h2002_000A, 2, 1'b0, 32'h0000_0100, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'h1122_3344, 0, 1'b0, 32'h0000_0040, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 32'hBAD0_BAD0, 3, 1'b0, 32'h0000_0044, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h0000_0048, 32'hCAFE_F00D, 32'h5555_AAAA, 1, 1'b0, 32'h0000_0048, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 32'h0000_0104, 32'h0, 32'h8C22_0004, 10, 1'b1, 32'h0000_0104, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'hA5A5_A5A5, 1, 1'b0, 32'hFFFF_FFFC, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 32'h0000_004C, 32'h0123_4567, 32'h7777_0000, 10, 1'b1, 32'h0000_004C, 1'b1};

    @(negedge clk);
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_din", mem_din, 32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk1("rst_ready", if_ready | d_ready, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single accesses from the table.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (vecs[i].is_data) begin
        d_ren = vecs[i].ren; d_wen = vecs[i].wen;
        d_addr = vecs[i].addr; d_wdata = vecs[i].wdata;
      end else begin
        if_req = 1'b1; if_addr = vecs[i].addr;
      end
      push(vecs[i].is_data, vecs[i].exp_we, vecs[i].exp_addr, vecs[i].wdata, vecs[i].dout);
      serve(vecs[i].delay, 1'b0, vecs[i].perturb);
    end

    // Collision: data first, fetch after DONE.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_0200;
    d_ren = 1'b1; d_wen = 1'b0; d_addr = 32'h0000_0040;
    push(1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'h600D_DA7A);
    push(1'b0, 1'b0, 32'h0000_0200, 32'h0, 32'h0BAD_F00D);
    serve(0, 1'b0, 1'b0);
    serve(1, 1'b0, 1'b0);

    // Starvation: continuous requests give D D D F D D D F.
    @(negedge clk);
    @(negedge clk);
    d_ren = 1'b1; d_wen = 1'b0; d_addr = 32'h0000_0080;
    if_req = 1'b1; if_addr = 32'h0000_0300;
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < 3; j++) push(1'b1, 1'b0, 32'h0000_0080, 32'h0, 32'h0000_D000 + 32'(r * 4 + j));
      push(1'b0, 1'b0, 32'h0000_0300, 32'h0, 32'hF0F0_0000 + 32'(r));
    end
    for (int g = 0; g < 8; g++) serve(0, 1'b1, 1'b0);
    d_ren = 1'b0; if_req = 1'b0;
    @(negedge clk);
    chk1("starve_idle_after", mem_req, 1'b0);

    // Async reset during a data access.
    @(negedge clk);
    d_ren = 1'b1; d_addr = 32'h0000_0050;
    @(negedge clk);
    chk1("pre_reset_req", mem_req, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk1("async_rst_req", mem_req, 1'b0);
    chk("async_rst_addr", mem_addr, 32'h0);
    d_ren = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    last_d = 32'h0;
    mem_ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      chk1("no_ready_after_rst", d_ready | if_ready, 1'b0);
      chk1("no_req_after_rst", mem_req, 1'b0);
    end
    chk("d_rdata_after_rst", d_rdata, 32'h0);
    if_req = 1'b1; if_addr = 32'h0000_0400;
    push(1'b0, 1'b0, 32'h0000_0400, 32'h0, 32'h1357_9BDF);
    serve(1, 1'b0, 1'b0);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
